// File: rtl/cabac_rate_pkg.sv
// cabac_rate_pkg: shared defaults and output beat type for the CABAC rate estimator
package cabac_rate_pkg;
  localparam int C1FLAG_NUMBER_DEF = 8;
  localparam int C2FLAG_NUMBER_DEF = 1;
  localparam int RICE_MAX_DEF = 4;
  typedef struct packed {
    logic [7:0] base_level;
    logic       escape;
    logic [2:0] rice_param;
    logic       last;
  } blc_beat_t;
endpackage

// File: rtl/blc_level_calc.sv
// blc_level_calc: combinational baseLevel, escape and remaining level from abs, c1Idx, c2Idx
module blc_level_calc
  import cabac_rate_pkg::*;
#(
  parameter int COEF_W = 16,
  parameter int IDX_W = 8,
  parameter int C1FLAG_NUMBER = C1FLAG_NUMBER_DEF,
  parameter int C2FLAG_NUMBER = C2FLAG_NUMBER_DEF
) (
  input  logic [COEF_W-1:0] abs_level,
  input  logic [IDX_W-1:0]  c1_idx,
  input  logic [IDX_W-1:0]  c2_idx,
  output logic [7:0]        base_level,
  output logic              escape,
  output logic [COEF_W-1:0] rem_level
);
  localparam logic [IDX_W-1:0] C1_N = IDX_W'(C1FLAG_NUMBER);
  localparam logic [IDX_W-1:0] C2_N = IDX_W'(C2FLAG_NUMBER);
  always_comb begin
    base_level = ~|abs_level ? 8'd0 : c1_idx < C1_N ? (c2_idx < C2_N ? 8'd3 : 8'd2) : 8'd1;
    escape = |abs_level && abs_level >= COEF_W'(base_level);
    rem_level = escape ? abs_level - COEF_W'(base_level) : '0;
  end
endmodule

// File: rtl/base_level_rice_tracker.sv
// base_level_rice_tracker: streaming c1/c2/Rice context tracker with one-deep output register.
// Define BLC_GT1_CTX_EN to add the greater1 context state and out_gt1_ctx.
module base_level_rice_tracker
  import cabac_rate_pkg::*;
#(
  parameter int COEF_W = 16,
  parameter int IDX_W = 8,
  parameter int C1FLAG_NUMBER = C1FLAG_NUMBER_DEF,
  parameter int C2FLAG_NUMBER = C2FLAG_NUMBER_DEF,
  parameter int RICE_MAX = RICE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_abs_level,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_base_level,
  output logic [IDX_W-1:0]  out_c1_idx,
  output logic [IDX_W-1:0]  out_c2_idx,
  output logic              out_escape,
  output logic [COEF_W-1:0] out_rem_level,
  output logic [2:0]        out_rice_param,
  output logic              out_last
`ifdef BLC_GT1_CTX_EN
  , output logic [1:0]      out_gt1_ctx
`endif
);
  localparam logic [IDX_W-1:0] C1_N = IDX_W'(C1FLAG_NUMBER);
  localparam logic [IDX_W-1:0] C2_N = IDX_W'(C2FLAG_NUMBER);
  localparam logic [2:0] R_MAX = 3'(RICE_MAX);
  logic [IDX_W-1:0] c1, c2;
  logic [2:0] rice;
  logic [7:0] base;
  logic esc;
  logic [COEF_W-1:0] rem;
  logic accept, nz, c1_lt, gt1, rice_up;
  blc_beat_t q;
  blc_level_calc #(
    .COEF_W(COEF_W), .IDX_W(IDX_W), .C1FLAG_NUMBER(C1FLAG_NUMBER), .C2FLAG_NUMBER(C2FLAG_NUMBER)
  ) u_calc (
    .abs_level(in_abs_level), .c1_idx(c1), .c2_idx(c2),
    .base_level(base), .escape(esc), .rem_level(rem)
  );
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  assign nz = |in_abs_level;
  assign c1_lt = c1 < C1_N;
  assign gt1 = in_abs_level > COEF_W'(1);
  // threshold 3<<rice widened so the shift never truncates
  assign rice_up = {5'd0, in_abs_level} > ((COEF_W+5)'(3) << rice);
  assign out_base_level = q.base_level;
  assign out_escape = q.escape;
  assign out_rice_param = q.rice_param;
  assign out_last = q.last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      c1 <= '0;
      c2 <= '0;
      rice <= '0;
      out_valid <= 1'b0;
      q <= '0;
      out_c1_idx <= '0;
      out_c2_idx <= '0;
      out_rem_level <= '0;
    end else if (clear) begin
      c1 <= '0;
      c2 <= '0;
      rice <= '0;
      out_valid <= 1'b0;
      q <= '0;
      out_c1_idx <= '0;
      out_c2_idx <= '0;
      out_rem_level <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      q <= '{base_level: base, escape: esc, rice_param: rice, last: in_last};
      out_c1_idx <= c1;
      out_c2_idx <= c2;
      out_rem_level <= rem;
      if (in_last) begin
        c1 <= '0;
        c2 <= '0;
        rice <= '0;
      end else if (nz) begin
        if (c1_lt) c1 <= c1 + 1'b1;
        if (c1_lt && gt1 && c2 < C2_N) c2 <= c2 + 1'b1;
        if (rice_up && rice < R_MAX) rice <= rice + 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
`ifdef BLC_GT1_CTX_EN
  logic [1:0] ctx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ctx <= 2'd1;
      out_gt1_ctx <= '0;
    end else if (clear) begin
      ctx <= 2'd1;
      out_gt1_ctx <= '0;
    end else if (accept) begin
      out_gt1_ctx <= ctx;
      if (in_last) ctx <= 2'd1;
      else if (nz && c1_lt) ctx <= gt1 ? 2'd0 : (ctx == 2'd1 || ctx == 2'd2) ? ctx + 2'd1 : ctx;
    end
`endif
endmodule
